tpm_sha_arbiter: RTL
====================

// Module: tpm_sha_arbiter
// PURPOSE
//  Shares the single sha1 core among C_NUM_REQ requesters (host command path, PCR-extend engine, ...).
//  Round-robin grant per message; the owner keeps a lock from its first chunk through its last chunk,
//  so multi-block hashes are never interleaved. Sits between the requesters and sha1 (init/next/chunk/digest).
// PARAMETERS
//  C_NUM_REQ          2    number of requesters (2..8)
//  C_SHA_CHUNK_SIZE   512  chunk width, bits
//  C_SHA_DIGEST_SIZE  160  digest width, bits
//  C_TIMEOUT_CYCLES   4096 lock watchdog limit (used only with TPM_SHA_ARB_TIMEOUT_EN)
// PORTS
//  clk          in  1                      single clock, rising edge
//  resetn       in  1                      asynchronous, active-low reset
//  req_valid    in  N                      requester i offers a chunk
//  req_first    in  N                      chunk i is first of a message (core init), else continuation (next)
//  req_last     in  N                      chunk i is last of message; lock released after its digest
//  req_chunk    in  N*C_SHA_CHUNK_SIZE     chunk i at [i*512 +: 512]
//  req_ready    out N                      one-cycle accept pulse for requester i
//  rsp_valid    out N                      one-cycle digest-ready pulse for requester i
//  rsp_err      out N                      one-cycle reject pulse for requester i
//  rsp_digest   out C_SHA_DIGEST_SIZE      registered digest, held until next response
//  owner        out $clog2(N)              current/last lock owner
//  locked       out 1                      lock held
//  sha_init     out 1                      to core, one-cycle pulse
//  sha_next     out 1                      to core, one-cycle pulse
//  sha_chunk    out C_SHA_CHUNK_SIZE       to core, registered, stable from issue until response
//  sha_ready    in  1                      from core
//  sha_valid    in  1                      from core, digest valid
//  sha_digest   in  C_SHA_DIGEST_SIZE      from core
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0, locked 0, owner 0.
//  States: IDLE -> ISSUE -> HOLD -> WAIT -> RESP -> IDLE.
//  IDLE, unlocked: grant = first i at/after rr pointer with req_valid&req_first. None -> stay.
//  IDLE, locked: only owner considered; other requesters wait (no ready, no err).
//  Reject: req_valid&!req_first from a non-owner, or while unlocked -> rsp_err[i] pulse, no issue;
//   checked in IDLE, lowest index first, one per cycle, only when no grant that cycle.
//  Owner sends req_first while locked -> legal restart: issued as init.
//  ISSUE (1 cycle): req_ready[g]=1, sha_chunk<=req_chunk[g], sha_init=req_first[g], sha_next=!req_first[g];
//   locked<=1, owner<=g, last flag latched from req_last[g].
//  HOLD (1 cycle): ignore core status (core drops ready one cycle after init/next).
//  WAIT: until sha_ready&sha_valid, then rsp_digest<=sha_digest.
//  RESP (1 cycle): rsp_valid[owner]=1; if last flag: locked<=0, rr<=(owner+1) mod N.
//  Latency, 1st chunk accepted to rsp_valid: core time + 3 cycles. Back-to-back chunks: 1 idle cycle min.
//  rr wraps N-1 -> 0. req_ready/rsp_valid/rsp_err never asserted in the same cycle for same i.
//  Reset mid-message: everything returns to reset values; no response for in-flight chunk.
// CONFIGURATION
//  TPM_SHA_ARB_TIMEOUT_EN defined: counter runs in IDLE while locked, cleared on each owner issue;
//   at C_TIMEOUT_CYCLES: rsp_err[owner] pulse, locked<=0, rr<=owner+1. Owner's next continuation is rejected.
//  Undefined: no counter; a lock is held indefinitely until the owner's last chunk.
// TESTING
//  req0 single chunk "abc" padded, first=last=1 -> rsp_valid[0], digest a9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d.
//  req0 and req1 both valid+first same cycle after reset -> req0 granted; after req0 last, req1 next.
//  req0 2-chunk message, req1 valid+first between chunks -> req1 not granted until req0 rsp after chunk 2.
//  req1 valid, first=0 while unlocked -> rsp_err[1] 1 cycle, sha_init/sha_next stay 0.
//  resetn low during WAIT -> outputs 0 asynchronously, no rsp_valid after release.
//  TIMEOUT_EN, C_TIMEOUT_CYCLES=16: req0 first chunk, then silent -> rsp_err[0] on 16th idle cycle, locked=0.

Source files
------------

// File: rtl/tpm_sha_arbiter.sv
// tpm_sha_arbiter: shares one sha1 core among C_NUM_REQ requesters.
// Round-robin grant per message; the granted requester holds a lock from its
// first chunk to its last so multi-block hashes are never interleaved.
// Optional feature: define TPM_SHA_ARB_TIMEOUT_EN to add a lock watchdog that
// frees a lock left idle for C_TIMEOUT_CYCLES cycles.
module tpm_sha_arbiter #(
    parameter int C_NUM_REQ         = 2,
    parameter int C_SHA_CHUNK_SIZE  = 512,
    parameter int C_SHA_DIGEST_SIZE = 160,
    parameter int C_TIMEOUT_CYCLES  = 4096
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic [C_NUM_REQ-1:0]                   req_valid,
    input  logic [C_NUM_REQ-1:0]                   req_first,
    input  logic [C_NUM_REQ-1:0]                   req_last,
    input  logic [C_NUM_REQ*C_SHA_CHUNK_SIZE-1:0]  req_chunk,
    output logic [C_NUM_REQ-1:0]                   req_ready,
    output logic [C_NUM_REQ-1:0]                   rsp_valid,
    output logic [C_NUM_REQ-1:0]                   rsp_err,
    output logic [C_SHA_DIGEST_SIZE-1:0]           rsp_digest,
    output logic [$clog2(C_NUM_REQ)-1:0]           owner,
    output logic                                   locked,
    output logic                                   sha_init,
    output logic                                   sha_next,
    output logic [C_SHA_CHUNK_SIZE-1:0]            sha_chunk,
    input  logic                                   sha_ready,
    input  logic                                   sha_valid,
    input  logic [C_SHA_DIGEST_SIZE-1:0]           sha_digest
);

    localparam int OW = $clog2(C_NUM_REQ);

    // Reject parameter sets the arbitration logic is not built for.
    if (C_NUM_REQ < 2 || C_NUM_REQ > 8 || C_TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("tpm_sha_arbiter: unsupported parameter set");
    end

    typedef enum logic [2:0] {IDLE, ISSUE, HOLD, WAIT, RESP} state_t;

    state_t                        state;
    logic [OW-1:0]                 rr;
    logic                          last_flag;
    logic                          grant_hit;
    logic [OW-1:0]                 grant_idx;
    logic                          rej_hit;
    logic [OW-1:0]                 rej_idx;
    logic [C_SHA_CHUNK_SIZE-1:0]   chunk_sel;
    int                            scan;

`ifdef TPM_SHA_ARB_TIMEOUT_EN
    localparam int TW = $clog2(C_TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
`endif

    // Next round-robin start position after index v, wrapping N-1 -> 0.
    function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] v);
        return (v == OW'(C_NUM_REQ - 1)) ? '0 : v + 1'b1;
    endfunction

    // Pick the grant (owner only while locked, else round-robin over first
    // chunks) and the lowest-index continuation that must be rejected.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        rej_hit   = 1'b0;
        rej_idx   = '0;
        scan      = 0;
        if (locked) begin
            if (req_valid[owner]) begin
                grant_hit = 1'b1;
                grant_idx = owner;
            end
        end else begin
            for (int k = 0; k < C_NUM_REQ; k++) begin
                scan = (int'(rr) + k) % C_NUM_REQ;
                if (!grant_hit && req_valid[scan] && req_first[scan]) begin
                    grant_hit = 1'b1;
                    grant_idx = OW'(scan);
                end
            end
        end
        for (int i = 0; i < C_NUM_REQ; i++) begin
            if (!rej_hit && req_valid[i] && !req_first[i] && !(locked && owner == OW'(i))) begin
                rej_hit = 1'b1;
                rej_idx = OW'(i);
            end
        end
        chunk_sel = req_chunk[int'(grant_idx)*C_SHA_CHUNK_SIZE +: C_SHA_CHUNK_SIZE];
    end

    // Message FSM: grant, issue to the core, wait for the digest, respond.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            rr         <= '0;
            last_flag  <= 1'b0;
            locked     <= 1'b0;
            owner      <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_err    <= '0;
            rsp_digest <= '0;
            sha_init   <= 1'b0;
            sha_next   <= 1'b0;
            sha_chunk  <= '0;
`ifdef TPM_SHA_ARB_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_err   <= '0;
            sha_init  <= 1'b0;
            sha_next  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_hit) begin
                        state                <= ISSUE;
                        req_ready[grant_idx] <= 1'b1;
                        sha_chunk            <= chunk_sel;
                        sha_init             <= req_first[grant_idx];
                        sha_next             <= !req_first[grant_idx];
                        locked               <= 1'b1;
                        owner                <= grant_idx;
                        last_flag            <= req_last[grant_idx];
`ifdef TPM_SHA_ARB_TIMEOUT_EN
                        tmo_cnt              <= '0;
`endif
                    end else begin
`ifdef TPM_SHA_ARB_TIMEOUT_EN
                        // A silent owner loses the lock; its later continuation is rejected.
                        if (locked && tmo_cnt == TW'(C_TIMEOUT_CYCLES - 1)) begin
                            rsp_err[owner] <= 1'b1;
                            locked         <= 1'b0;
                            rr             <= wrap_inc(owner);
                            tmo_cnt        <= '0;
                        end else begin
                            if (locked) begin
                                tmo_cnt <= tmo_cnt + 1'b1;
                            end
                            if (rej_hit) begin
                                rsp_err[rej_idx] <= 1'b1;
                            end
                        end
`else
                        if (rej_hit) begin
                            rsp_err[rej_idx] <= 1'b1;
                        end
`endif
                    end
                end
                ISSUE: state <= HOLD;
                // Core status is stale for one cycle after init/next.
                HOLD:  state <= WAIT;
                WAIT: begin
                    if (sha_ready && sha_valid) begin
                        rsp_digest       <= sha_digest;
                        rsp_valid[owner] <= 1'b1;
                        state            <= RESP;
                    end
                end
                RESP: begin
                    if (last_flag) begin
                        locked <= 1'b0;
                        rr     <= wrap_inc(owner);
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
